// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction-fetch stage plus the IF/ID pipeline register. It holds the PC,
//   fetches 32-bit words over a req/ack handshake and hands each word, its
//   opcode and PC+1 to decode. Decode applies back-pressure with a valid/stall
//   handshake. Jumps and branches redirect the PC and flush the stage.
//
// Ports
//   clock          : single clock, rising edge
//   reset_n        : asynchronous active-low reset
//   imem_req       : fetch request to instruction memory
//   imem_addr      : fetch address (always the PC register)
//   imem_ack       : memory returns imem_rdata this cycle (may coincide with req)
//   imem_rdata     : instruction word, meaningful only with imem_ack
//   redirect_valid : jump/branch taken, load redirect_pc and flush
//   redirect_pc    : redirect target
//   stall          : decode cannot take a new instruction this cycle
//   id_valid       : IF/ID register holds a live instruction
//   id_instr       : registered instruction word
//   id_opcode      : id_instr[31:27]
//   id_pc_plus1    : registered PC+1 of id_instr
module instr_fetch_unit #(
  parameter int                 ADDR_W   = 12,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [4:0]        id_opcode,
  output logic [ADDR_W-1:0] id_pc_plus1
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus1;
  logic              accept;
  logic              flush;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= BOOT;
    else          state <= state_nx;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Redirect outranks stall; BOOT always lasts one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    unique case (state)
      BOOT:    state_nx = FETCH;
      FETCH:   if (!redirect_valid && id_valid && stall) state_nx = HOLD;
      HOLD:    if (redirect_valid || !stall)             state_nx = FETCH;
      default: state_nx = BOOT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. The request is withdrawn combinationally in the very cycle
  // decode stalls on a live instruction, so nothing can be accepted then. In
  // HOLD the request returns as soon as stall drops, letting a zero-wait memory
  // refill the register in the same cycle the held word is consumed.
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req = (state != BOOT) && !(id_valid && stall);
  end

  assign imem_addr = pc;
  assign pc_plus1  = pc + ADDR_W'(1);
  assign accept    = imem_ack && imem_req && !redirect_valid && (!id_valid || !stall);
  assign flush     = redirect_valid && (state != BOOT);

  // ---------------------------------------------------------------------------
  // PC and IF/ID register. id_instr/id_pc_plus1 only move on accept, so they
  // keep their last contents while id_valid is low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc_plus1 <= '0;
    end else begin
      if (redirect_valid) pc <= redirect_pc;
      else if (accept)    pc <= pc_plus1;

      if (flush)                   id_valid <= 1'b0;
      else if (accept)             id_valid <= 1'b1;
      else if (id_valid && !stall) id_valid <= 1'b0;

      if (accept) begin
        id_instr    <= imem_rdata;
        id_pc_plus1 <= pc_plus1;
      end
    end
  end

  assign id_opcode = id_instr[31:27];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          stall;
  logic          id_valid;
  logic [31:0]   id_instr;
  logic [4:0]    id_opcode;
  logic [AW-1:0] id_pc_plus1;

  instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(12'h000)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_opcode      (id_opcode),
    .id_pc_plus1    (id_pc_plus1)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: what decode should observe, per the stage's rules.
  bit            m_boot;
  logic [AW-1:0] m_pc;
  bit            m_v;
  logic [31:0]   m_instr;
  logic [AW-1:0] m_pp1;

  typedef struct {
    logic          st;
    logic          rd;
    logic [AW-1:0] rp;
    logic          ack;
    logic          e_req;
    logic [AW-1:0] e_addr;
    logic          e_v;
    logic [31:0]   e_instr;
    logic [AW-1:0] e_pp1;
  } vec_t;

  vec_t vt[14];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  task automatic model_reset();
    m_boot  = 1'b1;
    m_pc    = 12'h000;
    m_v     = 1'b0;
    m_instr = '0;
    m_pp1   = '0;
  endtask

  // One clock cycle. Called shortly after a rising edge. ackmode: 0 = no ack,
  // 1 = ack whenever a request is up, 2 = ack regardless of request.
  task automatic cycle(input logic st, input logic rd, input logic [AW-1:0] rp,
                       input int ackmode, input bit rnd_data,
                       output logic s_req, output logic [AW-1:0] s_addr);
    bit          e_req, ack, acc;
    logic [31:0] d;
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rp;
    imem_ack       = 1'b0;
    imem_rdata     = $urandom;
    #1;
    e_req  = !m_boot && !(m_v && st);
    s_req  = imem_req;
    s_addr = imem_addr;
    chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    ack = (ackmode == 2) || (ackmode == 1 && imem_req);
    d   = rnd_data ? $urandom : (32'h2800_0000 | 32'(imem_addr));
    imem_ack   = ack;
    imem_rdata = d;
    acc = ack && e_req && !rd && (!m_v || !st);
    @(posedge clock);
    #1;
    if (m_boot) begin
      m_boot = 1'b0;
      if (rd) m_pc = rp;
    end else if (rd) begin
      m_pc = rp;
      m_v  = 1'b0;
    end else if (acc) begin
      m_instr = d;
      m_pp1   = m_pc + 1'b1;
      m_pc    = m_pc + 1'b1;
      m_v     = 1'b1;
    end else if (m_v && !st) begin
      m_v = 1'b0;
    end
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_v});
    chk("id_instr", id_instr, m_instr);
    chk("id_opcode", 32'(id_opcode), 32'(m_instr[31:27]));
    chk("id_pc_plus1", 32'(id_pc_plus1), 32'(m_pp1));
    imem_ack = 1'b0;
  endtask

  logic          s_req;
  logic [AW-1:0] s_addr;

  initial begin
    //        st rd rp       ack req addr     v  instr          pp1
    vt[0]  = '{0, 0, 12'h000, 0, 0, 12'h000, 0, 32'h0000_0000, 12'h000};
    vt[1]  = '{0, 0, 12'h000, 1, 1, 12'h000, 1, 32'h2800_0000, 12'h001};
    vt[2]  = '{0, 0, 12'h000, 1, 1, 12'h001, 1, 32'h2800_0001, 12'h002};
    vt[3]  = '{1, 0, 12'h000, 0, 0, 12'h002, 1, 32'h2800_0001, 12'h002};
    vt[4]  = '{1, 0, 12'h000, 1, 0, 12'h002, 1, 32'h2800_0001, 12'h002};
    vt[5]  = '{1, 0, 12'h000, 0, 0, 12'h002, 1, 32'h2800_0001, 12'h002};
    vt[6]  = '{0, 0, 12'h000, 1, 1, 12'h002, 1, 32'h2800_0002, 12'h003};
    vt[7]  = '{0, 1, 12'h0A0, 1, 1, 12'h003, 0, 32'h2800_0002, 12'h003};
    vt[8]  = '{0, 0, 12'h000, 0, 1, 12'h0A0, 0, 32'h2800_0002, 12'h003};
    vt[9]  = '{0, 0, 12'h000, 1, 1, 12'h0A0, 1, 32'h2800_00A0, 12'h0A1};
    vt[10] = '{1, 1, 12'hFFF, 1, 0, 12'h0A1, 0, 32'h2800_00A0, 12'h0A1};
    vt[11] = '{0, 0, 12'h000, 1, 1, 12'hFFF, 1, 32'h2800_0FFF, 12'h000};
    vt[12] = '{0, 0, 12'h000, 1, 1, 12'h000, 1, 32'h2800_0000, 12'h001};
    vt[13] = '{0, 0, 12'h000, 0, 1, 12'h001, 0, 32'h2800_0000, 12'h001};

    reset_n        = 1'b0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    model_reset();
    #11;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'h000);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_pp1", 32'(id_pc_plus1), 32'd0);
    #1;
    reset_n = 1'b1;

    // Directed table from reset: boot, zero-wait stream, stall, redirects, wrap.
    for (int i = 0; i < 14; i++) begin
      cycle(vt[i].st, vt[i].rd, vt[i].rp, vt[i].ack ? 2 : 0, 1'b0, s_req, s_addr);
      chk($sformatf("tbl%0d_req", i), {31'd0, s_req}, {31'd0, vt[i].e_req});
      chk($sformatf("tbl%0d_addr", i), 32'(s_addr), 32'(vt[i].e_addr));
      chk($sformatf("tbl%0d_valid", i), {31'd0, id_valid}, {31'd0, vt[i].e_v});
      chk($sformatf("tbl%0d_instr", i), id_instr, vt[i].e_instr);
      chk($sformatf("tbl%0d_opcode", i), 32'(id_opcode), 32'(vt[i].e_instr[31:27]));
      chk($sformatf("tbl%0d_pp1", i), 32'(id_pc_plus1), 32'(vt[i].e_pp1));
    end

    // Two-cycle-latency memory at PC 5.
    cycle(1'b0, 1'b1, 12'h005, 0, 1'b0, s_req, s_addr);
    cycle(1'b0, 1'b0, 12'h000, 0, 1'b0, s_req, s_addr);
    chk("lat_addr_w1", 32'(s_addr), 32'h005);
    cycle(1'b0, 1'b0, 12'h000, 0, 1'b0, s_req, s_addr);
    chk("lat_addr_w2", 32'(s_addr), 32'h005);
    cycle(1'b0, 1'b0, 12'h000, 1, 1'b0, s_req, s_addr);
    chk("lat_addr_ack", 32'(s_addr), 32'h005);
    chk("lat_pp1", 32'(id_pc_plus1), 32'h006);
    chk("lat_valid", {31'd0, id_valid}, 32'd1);
    cycle(1'b0, 1'b0, 12'h000, 0, 1'b0, s_req, s_addr);
    chk("lat_next_addr", 32'(s_addr), 32'h006);

    // Reset pulsed while a request is outstanding; late ack during BOOT.
    cycle(1'b0, 1'b1, 12'h123, 0, 1'b0, s_req, s_addr);
    cycle(1'b0, 1'b0, 12'h000, 0, 1'b0, s_req, s_addr);
    #2;
    reset_n  = 1'b0;
    imem_ack = 1'b1;
    #1;
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_addr", 32'(imem_addr), 32'h000);
    chk("async_valid", {31'd0, id_valid}, 32'd0);
    chk("async_instr", id_instr, 32'd0);
    chk("async_opcode", 32'(id_opcode), 32'd0);
    chk("async_pp1", 32'(id_pc_plus1), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    cycle(1'b0, 1'b0, 12'h000, 2, 1'b0, s_req, s_addr);
    chk("boot_late_ack_req", {31'd0, s_req}, 32'd0);
    chk("boot_late_ack_valid", {31'd0, id_valid}, 32'd0);
    cycle(1'b0, 1'b0, 12'h000, 1, 1'b0, s_req, s_addr);
    chk("post_rst_addr", 32'(s_addr), 32'h000);
    chk("post_rst_pp1", 32'(id_pc_plus1), 32'h001);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic          st, rd;
      logic [AW-1:0] rp;
      int            r, am;
      st = ($urandom % 10) < 3;
      rd = ($urandom % 20) == 0;
      rp = (($urandom % 4) == 0) ? (12'hFFE + 12'($urandom % 2)) : 12'($urandom);
      r  = $urandom % 10;
      am = (r < 6) ? 1 : ((r == 9) ? 2 : 0);
      cycle(st, rd, rp, am, 1'b1, s_req, s_addr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
